// File: rtl/rgmii_pkg.sv
// Shared RGMII receive types: speed codes, decode states, in-band status.
// Imported by rgmii_rx_decode and rgmii_inband_status.
package rgmii_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    GIG,
    NIB_LO,
    NIB_HI
  } rx_state_t;

  // Field order matches rxd[3:0] of an idle cycle.
  typedef struct packed {
    logic       duplex;
    logic [1:0] speed;
    logic       link;
  } inband_t;

  // 2'b11 is handled as 1000M.
  function automatic logic is_gig(input logic [1:0] s);
    return s[1];
  endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// In-band status filter: loads status after STABLE_CYCLES equal samples.
// Ports: clk, rst_n, sample_en, sample[3:0] in; status (inband_t) out.
module rgmii_inband_status
  import rgmii_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [3:0] sample,
  output inband_t    status
);

  localparam logic [7:0] LIM = 8'(STABLE_CYCLES);

  inband_t    cand_q, cand_d;
  inband_t    stat_q;
  inband_t    smp;
  logic [7:0] cnt_q, cnt_d;
  logic       load;

  assign smp = inband_t'(sample);

  // cnt_q is the run length of the current candidate, new sample included.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    load   = 1'b0;
    if (sample_en) begin
      if (smp == cand_q) begin
        cnt_d = (cnt_q >= LIM) ? LIM : cnt_q + 8'd1;
      end else begin
        cand_d = smp;
        cnt_d  = 8'd1;
      end
      load = (cnt_d == LIM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
      stat_q <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      if (load) stat_q <= cand_d;
    end
  end

  assign status = stat_q;

endmodule

// File: rtl/rgmii_rx_decode.sv
// RGMII RX decoder: DDR sample pairs to GMII bytes (1000M / 10-100M).
// Ports: clk, rst_n, ddr_q1/q2[4:0], speed in; gmii_*, link_* out.
// Macro RGMII_RX_INBAND_STATUS_EN compiles in the in-band status decoder.
module rgmii_rx_decode
  import rgmii_pkg::*;
#(
  parameter int STATUS_STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ddr_q1,
  input  logic [4:0] ddr_q2,
  input  logic [1:0] speed,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       gmii_rx_ce,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_full_duplex
);

  if (STATUS_STABLE_CYCLES < 1 || STATUS_STABLE_CYCLES > 255) begin : g_bad
    $error("STATUS_STABLE_CYCLES out of range 1..255");
  end

  logic       dv, er;
  rx_state_t  state, state_d;
  logic [1:0] spd_q, spd_d;
  logic [3:0] lo_q, lo_d;
  logic       erl_q, erl_d;
  logic [7:0] rxd_d;
  logic       dv_d, er_d, ce_d, emit;

  assign dv = ddr_q1[4];
  assign er = ddr_q1[4] ^ ddr_q2[4];

  always_comb begin
    state_d = state;
    spd_d   = spd_q;
    lo_d    = lo_q;
    erl_d   = erl_q;
    rxd_d   = 8'h00;
    dv_d    = 1'b0;
    er_d    = 1'b0;
    emit    = 1'b0;
    unique case (state)
      IDLE: begin
        er_d = er;
        if (dv) begin
          spd_d = speed;
          if (is_gig(speed)) begin
            state_d = GIG;
            rxd_d   = {ddr_q2[3:0], ddr_q1[3:0]};
            dv_d    = 1'b1;
          end else begin
            state_d = NIB_HI;
            lo_d    = ddr_q1[3:0];
            erl_d   = er;
            er_d    = 1'b0;
          end
        end
      end
      GIG: begin
        dv_d = dv;
        er_d = er;
        if (dv || er) rxd_d = {ddr_q2[3:0], ddr_q1[3:0]};
        if (!dv) state_d = IDLE;
      end
      NIB_HI: begin
        emit = 1'b1;
        dv_d = 1'b1;
        if (dv) begin
          state_d = NIB_LO;
          rxd_d   = {ddr_q1[3:0], lo_q};
          er_d    = erl_q | er;
        end else begin
          // Odd nibble count: flush the half byte as an error.
          state_d = IDLE;
          rxd_d   = {4'h0, lo_q};
          er_d    = 1'b1;
        end
      end
      NIB_LO: begin
        if (dv) begin
          state_d = NIB_HI;
          lo_d    = ddr_q1[3:0];
          erl_d   = er;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ce_d = (state == IDLE) || is_gig(spd_q) || emit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      spd_q      <= SPEED_1000;
      lo_q       <= 4'h0;
      erl_q      <= 1'b0;
      gmii_rxd   <= 8'h00;
      gmii_rx_dv <= 1'b0;
      gmii_rx_er <= 1'b0;
      gmii_rx_ce <= 1'b1;
    end else begin
      state      <= state_d;
      spd_q      <= spd_d;
      lo_q       <= lo_d;
      erl_q      <= erl_d;
      gmii_rxd   <= rxd_d;
      gmii_rx_dv <= dv_d;
      gmii_rx_er <= er_d;
      gmii_rx_ce <= ce_d;
    end
  end

`ifdef RGMII_RX_INBAND_STATUS_EN
  inband_t st;

  rgmii_inband_status #(
    .STABLE_CYCLES(STATUS_STABLE_CYCLES)
  ) u_status (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_en(!dv && !er),
    .sample   (ddr_q1[3:0]),
    .status   (st)
  );

  assign link_up          = st.link;
  assign link_speed       = st.speed;
  assign link_full_duplex = st.duplex;
`else
  assign link_up          = 1'b0;
  assign link_speed       = 2'b00;
  assign link_full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Self-checking bench for rgmii_rx_decode: vector table, directed
// sequences and random frames against a frame-level reference model.
module tb_rgmii_rx_decode;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] q1 = '0, q2 = '0;
  logic [1:0] speed = 2'b10;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv, gmii_rx_er, gmii_rx_ce;
  logic       link_up, link_full_duplex;
  logic [1:0] link_speed;

  rgmii_rx_decode #(.STATUS_STABLE_CYCLES(N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ddr_q1          (q1),
    .ddr_q2          (q2),
    .speed           (speed),
    .gmii_rxd        (gmii_rxd),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rx_er      (gmii_rx_er),
    .gmii_rx_ce      (gmii_rx_ce),
    .link_up         (link_up),
    .link_speed      (link_speed),
    .link_full_duplex(link_full_duplex)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference in-band status: last N idle samples, all equal -> status.
  int         hist[$];
  logic [3:0] st_m = 4'h0;

  typedef struct {
    logic [4:0] q1;
    logic [4:0] q2;
    logic [1:0] spd;
    logic [7:0] rxd;
    logic       dv;
    logic       er;
    logic       ce;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [4:0] a, logic [4:0] b,
                              logic [1:0] s, logic [7:0] r,
                              logic d, logic e, logic c);
    vec_t t;
    t.q1 = a; t.q2 = b; t.spd = s;
    t.rxd = r; t.dv = d; t.er = e; t.ce = c;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_st();
`ifdef RGMII_RX_INBAND_STATUS_EN
    return st_m;
`else
    return 4'h0;
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    st_m = 4'h0;
  endtask

  task automatic model_status(input logic [4:0] a, input logic [4:0] b);
    bit same;
    if (!a[4] && !(a[4] ^ b[4])) begin
      hist.push_back(int'(a[3:0]));
      if (hist.size() > N) void'(hist.pop_front());
      if (hist.size() == N) begin
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
        if (same) st_m = 4'(hist[0]);
      end
    end
  endtask

  task automatic chk_status(input string nm);
    logic [3:0] s;
    s = exp_st();
    chk({nm, ".link"}, link_up, s[0]);
    chk({nm, ".lspd"}, link_speed, s[2:1]);
    chk({nm, ".dup"}, link_full_duplex, s[3]);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".rxd"}, gmii_rxd, 8'h00);
    chk({nm, ".dv"}, gmii_rx_dv, 0);
    chk({nm, ".er"}, gmii_rx_er, 0);
    chk({nm, ".ce"}, gmii_rx_ce, 1);
    chk({nm, ".link"}, link_up, 0);
    chk({nm, ".lspd"}, link_speed, 0);
    chk({nm, ".dup"}, link_full_duplex, 0);
  endtask

  // Drive one input cycle; outputs checked just after the capturing edge.
  task automatic step(input logic [4:0] a, input logic [4:0] b,
                      input logic [1:0] s, input logic [7:0] erxd,
                      input logic edv, input logic eer,
                      input logic ece, input string nm);
    @(negedge clk);
    q1 = a; q2 = b; speed = s;
    model_status(a, b);
    @(posedge clk);
    #1;
    chk({nm, ".rxd"}, gmii_rxd, erxd);
    chk({nm, ".dv"}, gmii_rx_dv, edv);
    chk({nm, ".er"}, gmii_rx_er, eer);
    chk({nm, ".ce"}, gmii_rx_ce, ece);
    chk_status(nm);
  endtask

  logic       gig, e, pe;
  logic [1:0] fs;
  logic [3:0] lw, lo, nb, jk, d;
  logic [7:0] b8;
  int         n, g;

  function automatic logic [3:0] pick(input logic [3:0] w);
    return ($urandom_range(0, 4) == 0) ? 4'($urandom) : w;
  endfunction

  initial begin
    tbl.push_back(mk(5'h00, 5'h00, 2'd2, 8'h00, 0, 0, 1));
    tbl.push_back(mk(5'h15, 5'h15, 2'd2, 8'h55, 1, 0, 1));
    tbl.push_back(mk(5'h15, 5'h15, 2'd2, 8'h55, 1, 0, 1));
    tbl.push_back(mk(5'h15, 5'h15, 2'd2, 8'h55, 1, 0, 1));
    tbl.push_back(mk(5'h1D, 5'h15, 2'd2, 8'h5D, 1, 0, 1));
    tbl.push_back(mk(5'h00, 5'h00, 2'd2, 8'h00, 0, 0, 1));
    tbl.push_back(mk(5'h1A, 5'h13, 2'd3, 8'h3A, 1, 0, 1));
    tbl.push_back(mk(5'h1B, 5'h04, 2'd3, 8'h4B, 1, 1, 1));
    tbl.push_back(mk(5'h1C, 5'h15, 2'd3, 8'h5C, 1, 0, 1));
    tbl.push_back(mk(5'h00, 5'h00, 2'd3, 8'h00, 0, 0, 1));
    tbl.push_back(mk(5'h12, 5'h11, 2'd2, 8'h12, 1, 0, 1));
    tbl.push_back(mk(5'h0F, 5'h1F, 2'd2, 8'hFF, 0, 1, 1));
    tbl.push_back(mk(5'h03, 5'h12, 2'd2, 8'h00, 0, 1, 1));
    tbl.push_back(mk(5'h00, 5'h00, 2'd2, 8'h00, 0, 0, 1));
    tbl.push_back(mk(5'h15, 5'h1A, 2'd1, 8'h00, 0, 0, 1));
    tbl.push_back(mk(5'h15, 5'h13, 2'd1, 8'h55, 1, 0, 1));
    tbl.push_back(mk(5'h1D, 5'h1F, 2'd1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(5'h15, 5'h10, 2'd1, 8'h5D, 1, 0, 1));
    tbl.push_back(mk(5'h00, 5'h00, 2'd1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(5'h00, 5'h00, 2'd1, 8'h00, 0, 0, 1));
    tbl.push_back(mk(5'h11, 5'h10, 2'd0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(5'h12, 5'h10, 2'd0, 8'h21, 1, 0, 1));
    tbl.push_back(mk(5'h13, 5'h10, 2'd0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(5'h00, 5'h00, 2'd0, 8'h03, 1, 1, 1));
    tbl.push_back(mk(5'h00, 5'h00, 2'd0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(5'h17, 5'h10, 2'd1, 8'h00, 0, 0, 1));
    tbl.push_back(mk(5'h18, 5'h00, 2'd1, 8'h87, 1, 1, 1));
    tbl.push_back(mk(5'h19, 5'h00, 2'd1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(5'h1A, 5'h10, 2'd1, 8'hA9, 1, 1, 1));
    tbl.push_back(mk(5'h00, 5'h00, 2'd1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(5'h00, 5'h00, 2'd1, 8'h00, 0, 0, 1));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      step(tbl[i].q1, tbl[i].q2, tbl[i].spd, tbl[i].rxd,
           tbl[i].dv, tbl[i].er, tbl[i].ce, $sformatf("vec%0d", i));

    // In-band status: 0xD held four idle cycles.
    repeat (3) step(5'h0D, 5'h00, 2'd2, 8'h00, 0, 0, 1, "ib_hold");
`ifdef RGMII_RX_INBAND_STATUS_EN
    chk("ib_before4.link", link_up, 0);
`else
    chk("ib_before4.link", link_up, 0);
`endif
    step(5'h0D, 5'h00, 2'd2, 8'h00, 0, 0, 1, "ib_hold4");
`ifdef RGMII_RX_INBAND_STATUS_EN
    chk("ib_after4.link", link_up, 1);
    chk("ib_after4.lspd", link_speed, 2'b10);
    chk("ib_after4.dup", link_full_duplex, 1);
`else
    chk("ib_after4.link", link_up, 0);
`endif
    for (int k = 0; k < 8; k++)
      step((k % 2) ? 5'h0D : 5'h00, 5'h00, 2'd2, 8'h00, 0, 0, 1, "ib_alt");
    // Frame cycles freeze the run counter.
    step(5'h05, 5'h00, 2'd2, 8'h00, 0, 0, 1, "ib_frz");
    step(5'h05, 5'h00, 2'd2, 8'h00, 0, 0, 1, "ib_frz");
    step(5'h1E, 5'h1F, 2'd2, 8'hFE, 1, 0, 1, "ib_frz_dv");
    step(5'h05, 5'h00, 2'd2, 8'h00, 0, 0, 1, "ib_frz");
    step(5'h05, 5'h00, 2'd2, 8'h00, 0, 0, 1, "ib_frz4");

    // Speed change mid-frame is ignored, then reset mid-frame.
    step(5'h00, 5'h00, 2'd2, 8'h00, 0, 0, 1, "spd_idle");
    step(5'h11, 5'h12, 2'd2, 8'h21, 1, 0, 1, "spd_b0");
    step(5'h13, 5'h14, 2'd1, 8'h43, 1, 0, 1, "spd_b1");
    step(5'h15, 5'h16, 2'd1, 8'h65, 1, 0, 1, "spd_b2");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("rst_async");
    repeat (2) begin
      @(negedge clk);
      q1 = 5'h17; q2 = 5'h18;
      @(posedge clk);
      #1;
      chk_reset_vals("rst_hold");
    end
    @(negedge clk);
    q1 = 5'h00; q2 = 5'h00; speed = 2'd1;
    rst_n = 1'b1;
    step(5'h00, 5'h00, 2'd1, 8'h00, 0, 0, 1, "post_idle");
    step(5'h14, 5'h10, 2'd1, 8'h00, 0, 0, 1, "post_n0");
    step(5'h16, 5'h10, 2'd1, 8'h64, 1, 0, 1, "post_n1");
    step(5'h00, 5'h00, 2'd1, 8'h00, 0, 0, 0, "post_end");
    step(5'h00, 5'h00, 2'd1, 8'h00, 0, 0, 1, "post_idle2");

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      gig = 1'($urandom_range(0, 1));
      if (gig) fs = $urandom_range(0, 1) ? 2'b10 : 2'b11;
      else fs = 2'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: lw = 4'hD;
        1: lw = 4'h5;
        default: lw = 4'hB;
      endcase
      n = $urandom_range(1, 12);
      lo = 4'h0;
      pe = 1'b0;
      if (gig) begin
        for (int i = 0; i < n; i++) begin
          b8 = 8'($urandom);
          e = ($urandom_range(0, 5) == 0);
          step({1'b1, b8[3:0]}, {~e, b8[7:4]},
               (i == 0) ? fs : 2'($urandom),
               b8, 1, e, 1, "rnd_gig");
        end
      end else begin
        for (int j = 0; j < n; j++) begin
          nb = 4'($urandom);
          jk = 4'($urandom);
          e = (j > 0) && ($urandom_range(0, 5) == 0);
          if (j % 2 == 1) begin
            step({1'b1, nb}, {~e, jk}, 2'($urandom),
                 {nb, lo}, 1, e | pe, 1, "rnd_nib");
          end else begin
            step({1'b1, nb}, {~e, jk},
                 (j == 0) ? fs : 2'($urandom),
                 8'h00, 0, 0, (j == 0), "rnd_nib");
            lo = nb;
            pe = e;
          end
        end
      end
      d = pick(lw);
      jk = 4'($urandom);
      if (gig)
        step({1'b0, d}, {1'b0, jk}, 2'($urandom),
             8'h00, 0, 0, 1, "rnd_end");
      else if (n % 2)
        step({1'b0, d}, {1'b0, jk}, 2'($urandom),
             {4'h0, lo}, 1, 1, 1, "rnd_odd");
      else
        step({1'b0, d}, {1'b0, jk}, 2'($urandom),
             8'h00, 0, 0, 0, "rnd_end");
      g = $urandom_range(0, 6);
      for (int k = 0; k < g; k++) begin
        d = pick(lw);
        jk = 4'($urandom);
        e = ($urandom_range(0, 7) == 0);
        step({1'b0, d}, {e, jk}, 2'($urandom),
             8'h00, 0, e, 1, "rnd_gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
